mux_rr_arbiter: RTL and testbench

Round-robin arbiter and output register that shares one N-to-1 data multiplexer between `N_REQ` requesters using a valid/ready handshake. Each cycle it picks one valid requester by rotating priority and steers that requester's word through the select path into a single registered output. It then holds the word until the downstream consumer accepts it. It sits directly in front of the shared datapath resource and owns its `sel` sequencing.

---
 rtl/mux_rr_arbiter_pkg.sv | 16 +
 rtl/mux_rr_arbiter_if.sv | 40 ++++
 rtl/mux_rr_arbiter_rr_pick.sv | 33 +++
 rtl/mux_rr_arbiter.sv | 84 ++++++++
 tb/tb_mux_rr_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Holds the output-register state type and the source-index width rule.
package mux_arb_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_state_t;

   // A single requester still needs a 1-bit index.
   function automatic int src_w(input int n);
      if (n <= 1) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester-side and consumer-side handshake bundle of the arbiter.
// slave is the arbiter view, master is the driver/consumer view.
interface mux_rr_arbiter_if
   import mux_arb_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8
);

   localparam int SRC_W = src_w(N_REQ);

   logic [N_REQ-1:0]  req_valid;
   logic [DATA_W-1:0] req_data [N_REQ];
   logic [N_REQ-1:0]  req_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [SRC_W-1:0]  out_src;
   logic              out_ready;

   modport slave (
      input  req_valid,
      input  req_data,
      input  out_ready,
      output req_ready,
      output out_valid,
      output out_data,
      output out_src
   );

   modport master (
      output req_valid,
      output req_data,
      output out_ready,
      input  req_ready,
      input  out_valid,
      input  out_data,
      input  out_src
   );

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotating-priority search: first valid requester at or after ptr.
// Indices wrap at N_REQ so non-power-of-two counts never overflow.
module rr_pick
   import mux_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int SRC_W = 2
) (
   input  logic [N_REQ-1:0] req_valid,
   input  logic [SRC_W-1:0] ptr,
   output logic [SRC_W-1:0] gnt_idx,
   output logic             gnt_any
);

   int cand;

   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = 0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         if (!gnt_any && req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = SRC_W'(cand);
         end
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter steering one requester word per cycle into a
// registered output slot held until the consumer accepts it.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   mux_rr_arbiter_if.slave  bus
);

   localparam int SRC_W = src_w(N_REQ);

   arb_state_t        state_q, state_d;
   logic [SRC_W-1:0]  ptr_q, ptr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [SRC_W-1:0]  src_q, src_d;

   logic [SRC_W-1:0]  gnt_idx;
   logic              gnt_any;
   logic              load_en;
   logic              xfer;

   rr_pick #(
      .N_REQ (N_REQ),
      .SRC_W (SRC_W)
   ) u_pick (
      .req_valid (bus.req_valid),
      .ptr       (ptr_q),
      .gnt_idx   (gnt_idx),
      .gnt_any   (gnt_any)
   );

   // Unload and reload share one edge, so a full slot still accepts.
   assign load_en = (state_q == EMPTY) | bus.out_ready;
   assign xfer    = load_en & gnt_any & rst_n;

   always_comb begin
      bus.req_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         bus.req_ready[i] = xfer & (gnt_idx == SRC_W'(i));
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      src_d   = src_q;
      if (xfer) begin
         state_d = FULL;
         data_d  = bus.req_data[gnt_idx];
         src_d   = gnt_idx;
         if (int'(gnt_idx) == N_REQ - 1) begin
            ptr_d = '0;
         end else begin
            ptr_d = gnt_idx + 1'b1;
         end
      end else if (state_q == FULL && bus.out_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         ptr_q   <= '0;
         data_q  <= '0;
         src_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         src_q   <= src_d;
      end
   end

   assign bus.out_valid = (state_q == FULL);
   assign bus.out_data  = data_q;
   assign bus.out_src   = src_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: a 4-requester instance against a
// reference arbiter model, plus a 3-requester instance for wrap checks.
module tb_mux_rr_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   mux_rr_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus4 ();
   mux_rr_arbiter_if #(.N_REQ(3), .DATA_W(8)) bus3 ();

   mux_rr_arbiter #(.N_REQ(4), .DATA_W(8)) u4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   mux_rr_arbiter #(.N_REQ(3), .DATA_W(8)) u3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   int n_chk = 0;
   int n_err = 0;

   // Reference model state for the 4-requester instance.
   bit         m_full = 1'b0;
   int         m_ptr  = 0;
   logic [9:0] sb_q [$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock of the 4-requester instance checked against the model.
   task automatic step();
      int         g;
      bit         xfer;
      logic [3:0] exp_rdy;
      logic [9:0] e;
      logic [7:0] held;
      @(negedge clk);
      g = -1;
      for (int k = 0; k < 4; k++) begin
         int c;
         c = (m_ptr + k) % 4;
         if (g < 0 && bus4.req_valid[c]) g = c;
      end
      xfer = (!m_full || bus4.out_ready) && (g >= 0);
      exp_rdy = 4'b0000;
      if (xfer) exp_rdy[g] = 1'b1;
      chk("req_ready", 32'(bus4.req_ready), 32'(exp_rdy));
      held = bus4.out_data;
      if (xfer) begin
         sb_q.push_back({bus4.req_data[g], 2'(g)});
         m_ptr  = (g + 1) % 4;
         m_full = 1'b1;
      end else if (m_full && bus4.out_ready) begin
         m_full = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("out_valid", 32'(bus4.out_valid), 32'(m_full));
      chk("ptr", 32'(u4.ptr_q), 32'(m_ptr));
      if (xfer) begin
         if (sb_q.size() == 0) begin
            chk("sb_empty", 32'(1), 32'(0));
         end else begin
            e = sb_q.pop_front();
            chk("out_data", 32'(bus4.out_data), 32'(e[9:2]));
            chk("out_src", 32'(bus4.out_src), 32'(e[1:0]));
         end
      end else begin
         chk("out_hold", 32'(bus4.out_data), 32'(held));
      end
   endtask

   initial begin
      bus4.req_valid = '0;
      bus4.out_ready = 1'b0;
      bus3.req_valid = '0;
      bus3.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) bus4.req_data[i] = 8'hA0 + 8'(i);
      for (int i = 0; i < 3; i++) bus3.req_data[i] = 8'hB0 + 8'(i);

      repeat (3) @(posedge clk);
      #2;
      chk("rst_rdy", 32'(bus4.req_ready), 32'(0));
      chk("rst_valid", 32'(bus4.out_valid), 32'(0));
      rst_n = 1'b1;

      // Idle after reset.
      for (int s = 0; s < 10; s++) begin
         step();
         chk("idle_data", 32'(bus4.out_data), 32'(0));
         chk("idle_src", 32'(bus4.out_src), 32'(0));
      end

      // Full contention, one word per cycle in index order.
      bus4.out_ready = 1'b1;
      bus4.req_valid = 4'b1111;
      for (int s = 0; s < 5; s++) begin
         step();
         chk("cont_data", 32'(bus4.out_data), 32'(8'hA0 + 8'(s % 4)));
         chk("cont_src", 32'(bus4.out_src), 32'(s % 4));
      end

      // Sparse: 1 and 3 valid; first grant 1 moves ptr to 2.
      bus4.req_valid = 4'b1010;
      step();
      chk("sp_src0", 32'(bus4.out_src), 32'(1));
      chk("sp_ptr0", 32'(u4.ptr_q), 32'(2));
      for (int s = 0; s < 3; s++) begin
         step();
         chk("sp_src", 32'(bus4.out_src), (s == 1) ? 32'(1) : 32'(3));
         chk("sp_ptr", 32'(u4.ptr_q), (s == 1) ? 32'(2) : 32'(0));
      end

      // Back-pressure while holding 8'h55.
      bus4.req_valid = 4'b0001;
      bus4.req_data[0] = 8'h55;
      step();
      chk("bp_load", 32'(bus4.out_data), 32'(8'h55));
      bus4.req_valid = 4'b0100;
      bus4.req_data[2] = 8'h77;
      bus4.out_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         step();
         chk("bp_data", 32'(bus4.out_data), 32'(8'h55));
         chk("bp_rdy", 32'(bus4.req_ready), 32'(0));
      end
      bus4.out_ready = 1'b1;
      step();
      chk("bp_rel_data", 32'(bus4.out_data), 32'(8'h77));
      chk("bp_rel_src", 32'(bus4.out_src), 32'(2));
      bus4.req_valid = 4'b0000;

      // Drain: slot empties but keeps its last word.
      step();
      chk("drain_valid", 32'(bus4.out_valid), 32'(0));
      chk("drain_data", 32'(bus4.out_data), 32'(8'h77));
      step();

      // Refill, stall, then reset between clock edges.
      bus4.req_valid = 4'b0001;
      bus4.req_data[0] = 8'h99;
      step();
      bus4.req_valid = 4'b0000;
      bus4.out_ready = 1'b0;
      chk("pre_rst_valid", 32'(bus4.out_valid), 32'(1));
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus4.out_valid), 32'(0));
      chk("arst_data", 32'(bus4.out_data), 32'(0));
      chk("arst_ptr", 32'(u4.ptr_q), 32'(0));
      m_full = 1'b0;
      m_ptr  = 0;
      sb_q.delete();

      for (int i = 0; i < 4; i++) bus4.req_data[i] = 8'hA0 + 8'(i);
      bus4.req_valid = 4'b1111;
      bus4.out_ready = 1'b1;
      bus3.req_valid = 3'b111;
      bus3.out_ready = 1'b1;
      #1;
      chk("rst_rdy4", 32'(bus4.req_ready), 32'(0));
      chk("rst_rdy3", 32'(bus3.req_ready), 32'(0));
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // After release both instances grant from index 0.
      for (int s = 0; s < 5; s++) begin
         step();
         chk("post_src4", 32'(bus4.out_src), 32'(s % 4));
         chk("n3_src", 32'(bus3.out_src), 32'(s % 3));
         chk("n3_data", 32'(bus3.out_data), 32'(8'hB0 + 8'(s % 3)));
         chk("n3_valid", 32'(bus3.out_valid), 32'(1));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
